// File: rtl/rx_ds_pkg.sv
// Shared constants, mode enum and helpers for the rx_downsampler decimator.
package rx_ds_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int ACC_GUARD      = 4;

    localparam logic [1:0] FACTOR_2  = 2'b00;
    localparam logic [1:0] FACTOR_4  = 2'b01;
    localparam logic [1:0] FACTOR_8  = 2'b10;
    localparam logic [1:0] FACTOR_16 = 2'b11;

    typedef enum logic {
        DS_PICK    = 1'b0,
        DS_AVERAGE = 1'b1
    } ds_mode_t;

    // Guard bits let a 16-sample sum of full-scale inputs fit without wrapping.
    function automatic int acc_width(input int data_w);
        return data_w + ACC_GUARD;
    endfunction

    function automatic logic [2:0] factor_log2(input logic [1:0] code);
        case (code)
            FACTOR_2:  return 3'd1;
            FACTOR_4:  return 3'd2;
            FACTOR_8:  return 3'd3;
            FACTOR_16: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/rx_ds_fifo.sv
// Synchronous FIFO holding packed {I,Q} results; a pop frees a slot for a
// same-cycle push even when full.
module rx_ds_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_W'(DEPTH));
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset; the empty gate hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rx_downsampler.sv
// I/Q decimator (pick or integrate-and-dump, /2../16 or bypass) feeding an output FIFO.
// Define RX_DOWNSAMPLER_ROUND_EN to round averages half toward +inf instead of flooring.
module rx_downsampler
    import rx_ds_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             rx_data_i,
    input  logic [DATA_W-1:0]             rx_data_q,
    input  logic                          rx_data_valid,
    input  logic [1:0]                    downsampling_factor,
    input  logic                          bypass_enable,
    input  logic                          downsample_mode,
    output logic [DATA_W-1:0]             dn_data_i,
    output logic [DATA_W-1:0]             dn_data_q,
    output logic                          dn_data_valid,
    input  logic                          dn_data_ready,
    output logic [7:0]                    sample_count,
    output logic [$clog2(FIFO_DEPTH):0]   buffer_level,
    output logic                          overflow
);
    localparam int ACC_W = acc_width(DATA_W);

    logic [3:0]              phase;
    logic [1:0]              cfg_factor;
    ds_mode_t                cfg_mode;
    logic                    cfg_bypass;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;

    logic [1:0]              eff_factor;
    ds_mode_t                eff_mode;
    logic                    eff_bypass;
    logic [2:0]              lg;
    logic [3:0]              last_phase;
    logic                    group_done;
    logic                    push;
    logic                    pop;
    logic                    dropped;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic signed [ACC_W-1:0] ext_i;
    logic signed [ACC_W-1:0] ext_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic signed [ACC_W-1:0] avg_i;
    logic signed [ACC_W-1:0] avg_q;
    logic signed [ACC_W-1:0] round_add;
    logic [DATA_W-1:0]       res_i;
    logic [DATA_W-1:0]       res_q;
    logic [2*DATA_W-1:0]     head;
    logic                    unused_avg_bits;

    // The first sample of a group sees the live config; later ones use the latched copy.
    always_comb begin
        eff_factor = cfg_factor;
        eff_mode   = cfg_mode;
        eff_bypass = cfg_bypass;
        if (phase == 4'd0) begin
            eff_factor = downsampling_factor;
            eff_mode   = ds_mode_t'(downsample_mode);
            eff_bypass = bypass_enable;
        end
    end

    assign lg         = factor_log2(eff_factor);
    assign last_phase = 4'((5'd1 << lg) - 5'd1);
    assign group_done = eff_bypass || (phase == last_phase);
    assign push       = rx_data_valid && group_done;

    assign ext_i = {{ACC_GUARD{rx_data_i[DATA_W-1]}}, rx_data_i};
    assign ext_q = {{ACC_GUARD{rx_data_q[DATA_W-1]}}, rx_data_q};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;

`ifdef RX_DOWNSAMPLER_ROUND_EN
    assign round_add = ACC_W'(1) << (lg - 3'd1);
`else
    assign round_add = '0;
`endif

    assign avg_i = (sum_i + round_add) >>> lg;
    assign avg_q = (sum_q + round_add) >>> lg;
    assign unused_avg_bits = ^{avg_i[ACC_W-1:DATA_W], avg_q[ACC_W-1:DATA_W]};

    // A pick group never completes at phase 0, so the accumulator already holds the kept sample.
    always_comb begin
        res_i = rx_data_i;
        res_q = rx_data_q;
        if (!eff_bypass) begin
            if (eff_mode == DS_AVERAGE) begin
                res_i = avg_i[DATA_W-1:0];
                res_q = avg_q[DATA_W-1:0];
            end else begin
                res_i = acc_i[DATA_W-1:0];
                res_q = acc_q[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= 4'd0;
            cfg_factor <= FACTOR_2;
            cfg_mode   <= DS_PICK;
            cfg_bypass <= 1'b0;
            acc_i      <= '0;
            acc_q      <= '0;
        end else if (rx_data_valid) begin
            if (phase == 4'd0) begin
                cfg_factor <= downsampling_factor;
                cfg_mode   <= ds_mode_t'(downsample_mode);
                cfg_bypass <= bypass_enable;
                acc_i      <= ext_i;
                acc_q      <= ext_q;
            end else if (eff_mode == DS_AVERAGE) begin
                acc_i <= sum_i;
                acc_q <= sum_q;
            end
            phase <= group_done ? 4'd0 : phase + 4'd1;
        end
    end

    assign pop     = dn_data_valid && dn_data_ready;
    assign dropped = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= 8'd0;
            overflow     <= 1'b0;
        end else begin
            if (push && !dropped) begin
                sample_count <= sample_count + 8'd1;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    rx_ds_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({res_i, res_q}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (buffer_level)
    );

    assign dn_data_valid          = !fifo_empty;
    assign {dn_data_i, dn_data_q} = head;

endmodule

// File: tb/tb_rx_downsampler.sv
// Bench for rx_downsampler: directed scenarios pinned with literals, then
// randomized traffic checked every cycle against a queue-based group/FIFO model.
module tb_rx_downsampler;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

`ifdef RX_DOWNSAMPLER_ROUND_EN
    localparam int AVG_POS = 3;
    localparam int AVG_NEG = -2;
`else
    localparam int AVG_POS = 2;
    localparam int AVG_NEG = -3;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  rx_data_i;
    logic [DATA_W-1:0]  rx_data_q;
    logic               rx_data_valid;
    logic [1:0]         downsampling_factor;
    logic               bypass_enable;
    logic               downsample_mode;
    logic [DATA_W-1:0]  dn_data_i;
    logic [DATA_W-1:0]  dn_data_q;
    logic               dn_data_valid;
    logic               dn_data_ready;
    logic [7:0]         sample_count;
    logic [LEVEL_W-1:0] buffer_level;
    logic               overflow;

    int checks = 0;
    int passes = 0;

    // Model: samples of the open group, its latched config, and the expected FIFO contents.
    int grp_i[$];
    int grp_q[$];
    int grp_n;
    bit grp_avg;
    bit grp_byp;
    int out_i[$];
    int out_q[$];
    int exp_count;
    bit exp_ovf;

    always #5 clk = ~clk;

    rx_downsampler #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_data_i           (rx_data_i),
        .rx_data_q           (rx_data_q),
        .rx_data_valid       (rx_data_valid),
        .downsampling_factor (downsampling_factor),
        .bypass_enable       (bypass_enable),
        .downsample_mode     (downsample_mode),
        .dn_data_i           (dn_data_i),
        .dn_data_q           (dn_data_q),
        .dn_data_valid       (dn_data_valid),
        .dn_data_ready       (dn_data_ready),
        .sample_count        (sample_count),
        .buffer_level        (buffer_level),
        .overflow            (overflow)
    );

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int floor_div(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int reduce_group(input int g[$], input bit avg);
        int sum;
        sum = 0;
        if (!avg) return g[0];
        foreach (g[k]) sum += g[k];
`ifdef RX_DOWNSAMPLER_ROUND_EN
        return floor_div(sum + g.size() / 2, g.size());
`else
        return floor_div(sum, g.size());
`endif
    endfunction

    // Advances the model by one clock edge using the inputs about to be sampled.
    function automatic void modelStep(input bit valid, input int di, input int dq,
                                      input int factor, input bit byp, input bit mode,
                                      input bit ready);
        bit have;
        bit pop;
        int ri;
        int rq;
        have = 0;
        ri = 0;
        rq = 0;
        pop = (out_i.size() != 0) && ready;
        if (valid) begin
            if (grp_i.size() == 0) begin
                grp_n   = 2 << factor;
                grp_avg = mode;
                grp_byp = byp;
            end
            grp_i.push_back(di);
            grp_q.push_back(dq);
            if (grp_byp || grp_i.size() == grp_n) begin
                have = 1;
                ri = grp_byp ? di : reduce_group(grp_i, grp_avg);
                rq = grp_byp ? dq : reduce_group(grp_q, grp_avg);
                grp_i.delete();
                grp_q.delete();
            end
        end
        if (pop) begin
            void'(out_i.pop_front());
            void'(out_q.pop_front());
        end
        if (have) begin
            if (out_i.size() < DEPTH) begin
                out_i.push_back(ri);
                out_q.push_back(rq);
                exp_count = (exp_count + 1) % 256;
            end else begin
                exp_ovf = 1;
            end
        end
    endfunction

    task automatic checkOutput();
        bit exp_valid;
        exp_valid = (out_i.size() != 0);
        checkValue("valid", int'(dn_data_valid), int'(exp_valid));
        checkValue("level", int'(buffer_level), out_i.size());
        checkValue("sample_count", int'(sample_count), exp_count);
        checkValue("overflow", int'(overflow), int'(exp_ovf));
        if (exp_valid && dn_data_valid) begin
            checkValue("head_i", int'($signed(dn_data_i)), out_i[0]);
            checkValue("head_q", int'($signed(dn_data_q)), out_q[0]);
        end
    endtask

    // Drives one cycle at the falling edge, then checks after the next falling edge.
    task automatic applyStimulus(input bit valid, input int di, input int dq,
                                 input int factor, input bit byp, input bit mode,
                                 input bit ready);
        rx_data_valid       = valid;
        rx_data_i           = DATA_W'(di);
        rx_data_q           = DATA_W'(dq);
        downsampling_factor = 2'(factor);
        bypass_enable       = byp;
        downsample_mode     = mode;
        dn_data_ready       = ready;
        modelStep(valid, di, dq, factor, byp, mode, ready);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        rst           = 1'b1;
        rx_data_valid = 1'b0;
        dn_data_ready = 1'b0;
        grp_i.delete();
        grp_q.delete();
        out_i.delete();
        out_q.delete();
        exp_count = 0;
        exp_ovf   = 0;
        #1;
        checkValue("rst_valid", int'(dn_data_valid), 0);
        checkValue("rst_level", int'(buffer_level), 0);
        checkValue("rst_count", int'(sample_count), 0);
        checkValue("rst_overflow", int'(overflow), 0);
        checkValue("rst_data_i", int'(dn_data_i), 0);
        checkValue("rst_data_q", int'(dn_data_q), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rx_data_i           = '0;
        rx_data_q           = '0;
        rx_data_valid       = 1'b0;
        downsampling_factor = 2'b00;
        bypass_enable       = 1'b0;
        downsample_mode     = 1'b0;
        dn_data_ready       = 1'b0;
        doReset();

        // /2 pick: keeps 10 and 30, each visible one cycle after its group closes.
        applyStimulus(1, 10, 1, 0, 0, 0, 1);
        applyStimulus(1, 20, 2, 0, 0, 0, 1);
        checkValue("t1_first_valid", int'(dn_data_valid), 1);
        checkValue("t1_first_i", int'($signed(dn_data_i)), 10);
        applyStimulus(1, 30, 3, 0, 0, 0, 1);
        applyStimulus(1, 40, 4, 0, 0, 0, 1);
        checkValue("t1_second_i", int'($signed(dn_data_i)), 30);
        checkValue("t1_count", int'(sample_count), 2);

        // /4 average on positive and negative ramps.
        doReset();
        for (int k = 1; k <= 4; k++) applyStimulus(1, k, -k, 1, 0, 1, 1);
        checkValue("t2_avg_pos_i", int'($signed(dn_data_i)), AVG_POS);
        checkValue("t2_avg_neg_q", int'($signed(dn_data_q)), AVG_NEG);
        for (int k = 1; k <= 4; k++) applyStimulus(1, -k, k, 1, 0, 1, 1);
        checkValue("t2_avg_neg_i", int'($signed(dn_data_i)), AVG_NEG);
        checkValue("t2_avg_pos_q", int'($signed(dn_data_q)), AVG_POS);

        // Bypass with an idle gap.
        doReset();
        applyStimulus(1, 5, -5, 3, 1, 1, 1);
        checkValue("t3_byp_5", int'($signed(dn_data_i)), 5);
        applyStimulus(1, 6, -6, 3, 1, 1, 1);
        checkValue("t3_byp_6", int'($signed(dn_data_i)), 6);
        applyStimulus(0, 0, 0, 3, 1, 1, 1);
        checkValue("t3_gap_empty", int'(dn_data_valid), 0);
        applyStimulus(1, 7, -7, 3, 1, 1, 1);
        checkValue("t3_byp_7", int'($signed(dn_data_i)), 7);

        // Overflow with a stalled consumer, then drain in order.
        doReset();
        for (int k = 0; k < 20; k++) applyStimulus(1, k, -k, 0, 0, 0, 0);
        checkValue("t4_level_full", int'(buffer_level), 8);
        checkValue("t4_overflow", int'(overflow), 1);
        checkValue("t4_count", int'(sample_count), 8);
        checkValue("t4_head_first", int'($signed(dn_data_i)), 0);
        for (int k = 0; k < 7; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkValue("t4_head_last", int'($signed(dn_data_i)), 14);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkValue("t4_drained", int'(dn_data_valid), 0);
        checkValue("t4_overflow_sticky", int'(overflow), 1);

        // Mid-group factor change is ignored until the next group.
        doReset();
        applyStimulus(1, 1, 0, 1, 0, 0, 1);
        applyStimulus(1, 2, 0, 1, 0, 0, 1);
        checkValue("t5_no_early_close", int'(dn_data_valid), 0);
        applyStimulus(1, 3, 0, 0, 0, 0, 1);
        applyStimulus(1, 4, 0, 0, 0, 0, 1);
        checkValue("t5_group4_i", int'($signed(dn_data_i)), 1);
        applyStimulus(1, 5, 0, 0, 0, 0, 1);
        applyStimulus(1, 6, 0, 0, 0, 0, 1);
        checkValue("t5_group2_i", int'($signed(dn_data_i)), 5);

        // Reset in the middle of a group discards it and clears buffered output.
        doReset();
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        applyStimulus(1, 8, 0, 0, 0, 0, 0);
        checkValue("t6_pre_level", int'(buffer_level), 1);
        for (int k = 1; k <= 3; k++) applyStimulus(1, k, k, 1, 0, 1, 0);
        doReset();
        for (int k = 1; k <= 4; k++) applyStimulus(1, 4 * k, -4 * k, 1, 0, 1, 0);
        checkValue("t6_fresh_i", int'($signed(dn_data_i)), 10);
        checkValue("t6_fresh_q", int'($signed(dn_data_q)), -10);
        checkValue("t6_fresh_count", int'(sample_count), 1);

        // Randomized traffic with config changing freely mid-group.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) doReset();
            applyStimulus($urandom_range(0, 9) < 7,
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 2,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
